// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder (spi_per).
//
// Contents:
//   spi_per_state_t      responder FSM state encoding (IDLE, SHIFT)
//   SPI_SYNC_STAGES      number of synchronizer flops in front of each pin
//   SPI_MIN_HALF_PERIOD  minimum DCLK half-period, in clk_in cycles, that the
//                        responder can follow (sync latency plus one margin cycle)
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_per_state_t;

  localparam int unsigned SPI_SYNC_STAGES     = 2;
  localparam int unsigned SPI_MIN_HALF_PERIOD = 4;

endpackage

// File: rtl/sync_edge.sv
// Pin synchronizer with edge strobes.
//
// A SPI_SYNC_STAGES-deep synchronizer followed by one history flop. The edge
// strobes are combinational from the synchronized level and its history, so a
// pin change sampled at edge k shows up as a strobe in the cycle after edge k+1.
//
// Parameters:
//   ResetVal  value every flop takes in reset (CS idles high, DCLK low)
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   d_i      asynchronous pin input
//   level_o  synchronized pin level
//   rise_o   one-cycle strobe on a synchronized 0->1 transition
//   fall_o   one-cycle strobe on a synchronized 1->0 transition
module sync_edge
  import spi_pkg::*;
#(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;
  logic                       hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SPI_SYNC_STAGES{ResetVal}};
      hist_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SPI_SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SPI_SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_per.sv
// SPI responder, mode 0, MSB first, running entirely in the clk_in domain.
//
// DCLK, CS and COPI are oversampled through sync_edge instances. Received bits
// are shifted in on DCLK rising edges; the response word is shifted out on
// falling edges, with CIPO always driven from the MSB of the shift-out register.
// Several words may follow each other inside one CS assertion.
//
// Parameters:
//   DATA_WIDTH     bits per word
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous active-low reset
//   chip_clk_in    DCLK from the controller (asynchronous)
//   chip_sel_in    CS, active low (asynchronous)
//   chip_data_in   COPI (asynchronous)
//   chip_data_out  CIPO
//   tx_data_in     response word, accepted on tx_valid_in && tx_ready_out
//   tx_valid_in    tx_data_in is valid
//   tx_ready_out   one-word holding register is empty
//   rx_data_out    last complete received word, held until the next one
//   rx_valid_out   one-cycle pulse when a word completes
//   abort_out      one-cycle pulse when CS deasserts mid-word
//   underrun_out   one-cycle pulse when a word starts with the holding register empty
module spi_per
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  chip_data_in,
  output logic                  chip_data_out,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid_in,
  output logic                  tx_ready_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid_out,
  output logic                  abort_out,
  output logic                  underrun_out
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic copi, copi_rise, copi_fall;

  sync_edge #(
    .ResetVal (1'b0)
  ) u_sync_sclk (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .d_i     (chip_clk_in),
    .level_o (sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(
    .ResetVal (1'b1)
  ) u_sync_cs (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .d_i     (chip_sel_in),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(
    .ResetVal (1'b0)
  ) u_sync_copi (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .d_i     (chip_data_in),
    .level_o (copi),
    .rise_o  (copi_rise),
    .fall_o  (copi_fall)
  );

  // Only the strobes of DCLK/CS and the level of COPI are used.
  logic unused_sync;
  assign unused_sync = ^{sclk_level, cs_level, copi_rise, copi_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_per_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  abort_q, abort_d;
  logic                  underrun_q, underrun_d;

  logic            load;
  logic            tx_fire;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;
    cnt_inc     = cnt_q + CntW'(1);
    tx_fire     = tx_valid_in & ~hold_full_q;

    unique case (state_q)
      IDLE: begin
        // DCLK edges are ignored here.
        if (cs_fall) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], copi};
          if (cnt_inc == CntW'(DATA_WIDTH)) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            load       = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (sclk_fall && (cnt_q != '0)) begin
          // A zero count means the next word was just reloaded on the final
          // rising edge; its MSB must stay on CIPO until the next rising edge.
          tx_shift_d = tx_shift_q << 1;
        end
        // The rising edge above is processed first, so a word completing on
        // the same cycle as cs_rise leaves a zero count and no abort.
        if (cs_rise) begin
          if (cnt_d != '0) begin
            abort_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading empties the holding register; a handshake in the same cycle sees
    // the old (empty) state, so the load takes zeros and the new word is kept.
    if (load) begin
      tx_shift_d  = hold_full_q ? hold_q : '0;
      underrun_d  = ~hold_full_q;
      hold_full_d = 1'b0;
    end
    if (tx_fire) begin
      hold_d      = tx_data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      abort_q     <= abort_d;
      underrun_q  <= underrun_d;
    end
  end

  assign chip_data_out = tx_shift_q[DATA_WIDTH-1];
  assign tx_ready_out  = ~hold_full_q;
  assign rx_data_out   = rx_data_q;
  assign rx_valid_out  = rx_valid_q;
  assign abort_out     = abort_q;
  assign underrun_out  = underrun_q;

endmodule
